mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 59 +++++
 tb/tb_mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access,
// data first by default, with a burst limit so a waiting fetch cannot starve.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DBURST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  owner_t owner, ownerNext;
  logic [3:0] dCnt, dCntNext;
  logic fetchFirst;
  // grants are gated by rst so everything reads idle while reset is held
  always_comb begin
    fetchFirst = if_req && dCnt == 4'(MAX_DBURST);
    if_gnt     = rst && if_req && (!d_req || fetchFirst);
    d_gnt      = rst && d_req && !fetchFirst;
    stall      = rst && if_req && !if_gnt;
    mem_en     = if_gnt || d_gnt;
    mem_we     = d_gnt && d_we;
    mem_addr   = d_gnt ? d_addr : if_addr;
    mem_wdata  = d_wdata;
    if_rvalid  = owner == OWN_IF;
    d_rvalid   = owner == OWN_D;
    if_rdata   = mem_rdata;
    d_rdata    = mem_rdata;
    dCntNext   = (!if_req || if_gnt) ? 4'd0 : dCnt + 4'(d_gnt);
    ownerNext  = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dCnt  <= '0;
      owner <= OWN_NONE;
    end else begin
      dCnt  <= dCntNext;
      owner <= ownerNext;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a behavioural arbitration model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 3;
  logic clk = 0, rst = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0, mem_addr;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0, if_rdata, d_rdata, mem_wdata;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
  int checks = 0, errors = 0;
  int dataStreak = 0;
  int expOwner = 0;
  bit lastIf, lastD;
  logic [4:0] pat;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DBURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".if_gnt"}, 64'(if_gnt), 0);
    chk({tag, ".d_gnt"}, 64'(d_gnt), 0);
    chk({tag, ".stall"}, 64'(stall), 0);
    chk({tag, ".mem_en"}, 64'(mem_en), 0);
    chk({tag, ".mem_we"}, 64'(mem_we), 0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 0);
    chk({tag, ".d_rvalid"}, 64'(d_rvalid), 0);
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] rd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; mem_rdata = rd;
  endtask

  // Reference: data wins unless a fetch has already waited through MAXB data grants;
  // a read granted this cycle returns its data to the same requester next cycle.
  task automatic model();
    bit expIf, expD;
    expD  = d_req && !(if_req && dataStreak >= MAXB);
    expIf = if_req && !expD;
    chk("if_gnt", 64'(if_gnt), 64'(expIf));
    chk("d_gnt", 64'(d_gnt), 64'(expD));
    chk("stall", 64'(stall), 64'(if_req && !expIf));
    chk("mem_en", 64'(mem_en), 64'(expIf || expD));
    chk("mem_we", 64'(mem_we), 64'(expD && d_we));
    if (expIf || expD) chk("mem_addr", 64'(mem_addr), 64'(expD ? d_addr : if_addr));
    if (expD && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    chk("if_rvalid", 64'(if_rvalid), 64'(expOwner == 1));
    chk("d_rvalid", 64'(d_rvalid), 64'(expOwner == 2));
    if (expOwner == 1) chk("if_rdata", 64'(if_rdata), 64'(mem_rdata));
    if (expOwner == 2) chk("d_rdata", 64'(d_rdata), 64'(mem_rdata));
    expOwner   = expIf ? 1 : (expD && !d_we) ? 2 : 0;
    dataStreak = (if_req && expD) ? dataStreak + 1 : 0;
    lastIf = expIf;
    lastD  = expD;
  endtask

  task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                     input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] rd);
    @(negedge clk);
    drive(ir, ia, dr, dw, da, dwd, rd);
    #1 model();
  endtask

  initial begin
    logic ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd;
    drive(1, 32'h10, 1, 0, 32'h100, 0, 0);
    @(negedge clk); #1 chkIdle("reset");
    @(negedge clk); #1 chkIdle("reset2");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    #1 model();
    // fetch only, data returns next cycle
    cyc(1, 32'h10, 0, 0, 0, 0, 0);
    chk("fetch.mem_addr", 64'(mem_addr), 64'h10);
    cyc(0, 0, 0, 0, 0, 0, 32'h20080005);
    chk("fetch.if_rdata", 64'(if_rdata), 64'h20080005);
    chk("fetch.if_rvalid", 64'(if_rvalid), 1);
    // simultaneous: data load wins, fetch stalls
    cyc(1, 32'h20, 1, 0, 32'h100, 0, 0);
    chk("simul.stall", 64'(stall), 1);
    cyc(0, 0, 0, 0, 0, 0, 32'h11112222);
    chk("simul.d_rvalid", 64'(d_rvalid), 1);
    // starvation guard: d,d,d,if,d
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h30, 1, 0, 32'h140 + 32'(i * 4), 0, 32'(i));
      pat = {pat[3:0], if_gnt};
    end
    chk("starve.pattern", 64'(pat), 64'b00010);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // store: no read data afterwards
    cyc(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0);
    chk("store.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 32'h55555555);
    // fetch request dropped before grant
    cyc(1, 32'h44, 1, 0, 32'h48, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h66);
    cyc(0, 0, 0, 0, 0, 0, 32'h77);
    // alternating fetch / load
    cyc(1, 32'h0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h40, 0, 32'hAAAA0001);
    cyc(0, 0, 0, 0, 0, 0, 32'hBBBB0002);
    chk("alt.d_rdata", 64'(d_rdata), 64'hBBBB0002);
    // reset with a fetch read outstanding
    cyc(1, 32'h80, 0, 0, 0, 0, 0);
    #2 rst = 0;
    #1 chkIdle("rst_mid");
    @(negedge clk); #1 chkIdle("rst_hold");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 32'h99);
    rst = 1;
    dataStreak = 0;
    expOwner = 0;
    #1 model();
    cyc(0, 0, 0, 0, 0, 0, 32'h98);
    // random traffic; requests stay held until granted
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dwd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ir && $urandom_range(0, 2) != 0) begin ir = 1; ia = $urandom & ~32'h3; end
      if (!dr && $urandom_range(0, 2) != 0) begin
        dr = 1; dw = 1'($urandom); da = $urandom & ~32'h3; dwd = $urandom;
      end
      cyc(ir, ia, dr, dw, da, dwd, $urandom);
      if (lastIf) ir = 0;
      if (lastD) dr = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
